ppfifo_sync: RTL and testbench
==============================

Name: ppfifo_sync

Overview:
Single-clock ping-pong FIFO: the responder on both ends of the ppfifo protocol. Its write side answers ppfifo producers, such as adapters that drive o_write_activate/o_write_stb. Its read side answers ppfifo consumers, such as adapters that drive o_read_activate/o_read_stb. Two banks let a producer fill one bank while a consumer drains the other. It is used as the buffering element between PCIe-side and Wishbone-side engines running on one clock.

Parameters:
DATA_WIDTH, 32, width of each data word
ADDRESS_WIDTH, 9, log2 of bank depth; DEPTH = 2**ADDRESS_WIDTH words per bank (512)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
o_write_ready  output  2  bit n = bank n empty and available to producer
i_write_activate  input  2  producer claims bank n; one-hot
o_write_size  output  24  constant DEPTH, zero-extended
i_write_stb  input  1  write i_write_data into the active bank
i_write_data  input  DATA_WIDTH  write data
o_read_ready  output  1  a filled bank is available to consumer
i_read_activate  input  1  consumer claims the offered bank
o_read_size  output  24  word count of the offered/active bank
i_read_stb  input  1  consume current o_read_data
o_read_data  output  DATA_WIDTH  first-word-fall-through read data
o_overflow  output  1  sticky: write strobe dropped (bank full or no valid activate)
o_underflow  output  1  sticky: read strobe beyond o_read_size or while not active

Behaviour:
- Reset (rst=0, asynchronous):
  - all outputs return to reset values: o_write_ready=2'b11, o_read_ready=0, o_read_size=0, o_read_data=0, o_overflow=0, o_underflow=0;
  - both banks EMPTY, fill-order tracker cleared;
  - RAM contents not reset.
- Per-bank state machine: EMPTY -> WRITING -> FULL -> READING -> EMPTY.
- EMPTY -> WRITING: i_write_activate[n]=1 while o_write_ready[n]=1.
  - o_write_ready[n] drops the cycle after the activate is sampled.
  - Activating a bank whose ready bit is 0 is ignored.
  - i_write_activate=2'b11 is illegal: both bits ignored, no state change.
- WRITING:
  - each i_write_stb stores data at address {n, wcount[n]} and increments wcount[n] (ADDRESS_WIDTH+1 bits).
  - A strobe with wcount[n]==DEPTH is dropped and sets o_overflow.
- WRITING -> FULL: on the cycle i_write_activate[n] is sampled low.
  - If wcount[n]==0 the bank goes to EMPTY instead; o_write_ready[n] reasserts the next cycle.
  - A FULL bank records its count and fill order.
- Read offer:
  - rd_sel = oldest FULL bank by completion order.
  - If both banks complete in the same cycle, bank 0 is oldest.
  - o_read_ready=1 and o_read_size=count[rd_sel] the cycle after rd_sel becomes FULL, provided no bank is READING.
- FULL -> READING: i_read_activate sampled high while o_read_ready=1.
  - o_read_ready drops next cycle; o_read_size holds.
  - An activate while o_read_ready=0 is ignored until ready rises; the consumer must wait for ready.
- READING:
  - o_read_data shows word rcount; it is valid from the cycle after activate is sampled.
  - The sync-read RAM is pre-addressed with word 0 while the bank is offered.
  - On i_read_stb, rcount increments and the next word appears on the following cycle. The RAM read address is rcount+1 when a strobe is present, else rcount, so back-to-back strobes are supported.
  - A strobe with rcount>=o_read_size is ignored and sets o_underflow.
- READING -> EMPTY: i_read_activate sampled low.
  - Unread words are discarded.
  - o_write_ready[n] reasserts the next cycle; o_read_size clears to 0.
  - The other bank, if FULL, is offered the following cycle.
- Concurrency:
  - write on one bank and read on the other proceed in the same cycle independently;
  - the write side may also re-activate a just-released bank one cycle after its ready reasserts.
- o_write_size is constant; size outputs are zero-extended from ADDRESS_WIDTH+1 bits.
- Sticky flags clear only on reset.

Decomposition:
- Package ppfifo_pkg holds:
  - bank state encoding (EMPTY, WRITING, FULL, READING);
  - PPFIFO_SIZE_WIDTH=24;
  - helper constant for DEPTH derivation.
- One sub-module, ppfifo_dpram: simple dual-port RAM, one write port and one synchronous read port.
  - Depth is 2*DEPTH; the bank select is the address MSB.
  - Instantiated once.
- Bank state, counters, order tracking and handshakes live in ppfifo_sync.

Test Plan:
- Reset: hold rst=0 mid-operation, then release -> o_write_ready=2'b11, o_read_ready=0, o_read_size=0, o_write_size=512, flags 0, with outputs changing without a clock edge.
- Basic transfer: activate bank0, write 0xA0..0xA3, release -> o_read_ready=1 one cycle later with o_read_size=4. Activate read, strobe 4 back-to-back -> data A0,A1,A2,A3. Release -> o_write_ready[0]=1 the next cycle.
- Fill order: write bank1 with 3 words (0xB0..0xB2), then bank0 with 2 (0xC0,0xC1) -> first offer is size 3 with B0..B2; second offer is size 2 with C0,C1.
- Overflow: 514 strobes into bank0 -> o_read_size=512 and o_overflow=1; the read returns the first 512 words in order.
- Degenerate cases:
  - zero-strobe activate/release on bank1 -> o_read_ready stays 0 and o_write_ready[1] is back to 1 the next cycle;
  - read strobe after 4/4 words -> o_underflow=1.
- Concurrent/partial: write bank1 while reading bank0 with random stb gaps. Release the read after 2 of 4 words -> bank0 is EMPTY next cycle, and bank1 is offered the following cycle with correct data.

Source files
------------

// File: rtl/ppfifo_pkg.sv
// Shared definitions for the single-clock ping-pong FIFO: bank state encoding,
// size-port width and the bank depth derivation.
package ppfifo_pkg;

  localparam int PPFIFO_SIZE_WIDTH = 24;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_WRITING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;
  localparam logic [1:0] ST_READING = 2'd3;

  typedef logic [1:0] bank_state_t;

  function automatic int ppfifo_depth(input int address_width);
    return 1 << address_width;
  endfunction

endpackage

// File: rtl/ppfifo_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Only the read register is reset; the array contents are not.
module ppfifo_dpram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata <= '0;
    else      rdata <= mem[raddr];
  end

endmodule

// File: rtl/ppfifo_sync.sv
// Single-clock ping-pong FIFO: two banks, each cycling EMPTY -> WRITING -> FULL
// -> READING -> EMPTY, so a producer fills one bank while a consumer drains the other.
module ppfifo_sync
  import ppfifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [1:0]                   o_write_ready,
  input  logic [1:0]                   i_write_activate,
  output logic [PPFIFO_SIZE_WIDTH-1:0] o_write_size,
  input  logic                         i_write_stb,
  input  logic [DATA_WIDTH-1:0]        i_write_data,
  output logic                         o_read_ready,
  input  logic                         i_read_activate,
  output logic [PPFIFO_SIZE_WIDTH-1:0] o_read_size,
  input  logic                         i_read_stb,
  output logic [DATA_WIDTH-1:0]        o_read_data,
  output logic                         o_overflow,
  output logic                         o_underflow
);

  localparam int CW = ADDRESS_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(ppfifo_depth(ADDRESS_WIDTH));

  // Handshake: a bank is granted on the edge that samples its activate bit with
  // the matching ready high; dropping the activate bit hands the bank back.
  bank_state_t [1:0]   bank_state;
  logic [1:0][CW-1:0]  wcount;
  logic                oldest;
  logic                rd_active, rd_bank, read_ready_r;
  logic [CW-1:0]       rd_size, rcount;

  logic                act_ok;
  logic [1:0]          wr_start, wr_hit, wr_done, fill, full;
  logic                wr_bank, wr_en, rd_sel, rd_accept, rd_release, rd_ok;
  logic [CW-1:0]       wr_cnt, rcount_nxt;
  logic [ADDRESS_WIDTH-1:0] rd_word;
  logic [CW-1:0]       waddr, raddr;

  assign act_ok = (i_write_activate != 2'b11);

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      wr_start[n] = act_ok && i_write_activate[n] && (bank_state[n] == ST_EMPTY);
      wr_hit[n]   = act_ok && i_write_activate[n] && (bank_state[n] == ST_WRITING);
      wr_done[n]  = act_ok && !i_write_activate[n] && (bank_state[n] == ST_WRITING);
      fill[n]     = wr_done[n] && (wcount[n] != '0);
      full[n]     = (bank_state[n] == ST_FULL);
      o_write_ready[n] = (bank_state[n] == ST_EMPTY);
    end
  end

  assign wr_bank = wr_hit[1];
  assign wr_cnt  = wcount[wr_bank];
  assign wr_en   = i_write_stb && (|wr_hit) && (wr_cnt < DEPTH_C);
  assign waddr   = {wr_bank, wr_cnt[ADDRESS_WIDTH-1:0]};

  // The oldest-full bit only matters when both banks are FULL at once.
  assign rd_sel     = (&full) ? oldest : (full[1] & ~full[0]);
  assign rd_accept  = read_ready_r && i_read_activate;
  assign rd_release = rd_active && !i_read_activate;
  assign rd_ok      = rd_active && i_read_stb && (rcount < rd_size);
  assign rcount_nxt = rcount + CW'(1);
  assign rd_word    = rd_ok ? rcount_nxt[ADDRESS_WIDTH-1:0] : rcount[ADDRESS_WIDTH-1:0];
  // While idle the RAM is pre-addressed at word 0 of the offered bank.
  assign raddr      = rd_active ? {rd_bank, rd_word} : {rd_sel, {ADDRESS_WIDTH{1'b0}}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_state <= {ST_EMPTY, ST_EMPTY};
      wcount     <= '0;
      oldest     <= 1'b0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (wr_start[n]) begin
          bank_state[n] <= ST_WRITING;
          wcount[n]     <= '0;
        end else if (wr_done[n]) begin
          bank_state[n] <= fill[n] ? ST_FULL : ST_EMPTY;
        end else if (wr_en && (wr_bank == 1'(n))) begin
          wcount[n] <= wcount[n] + CW'(1);
        end else if (rd_accept && (rd_sel == 1'(n))) begin
          bank_state[n] <= ST_READING;
        end else if (rd_release && (rd_bank == 1'(n))) begin
          bank_state[n] <= ST_EMPTY;
        end
      end
      if (&fill)                   oldest <= 1'b0;
      else if (fill[0] && !full[1]) oldest <= 1'b0;
      else if (fill[1] && !full[0]) oldest <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_active    <= 1'b0;
      rd_bank      <= 1'b0;
      read_ready_r <= 1'b0;
      rd_size      <= '0;
      rcount       <= '0;
      o_overflow   <= 1'b0;
      o_underflow  <= 1'b0;
    end else begin
      if (rd_accept)  rcount <= '0;
      else if (rd_ok) rcount <= rcount_nxt;

      if (rd_accept) begin
        rd_active    <= 1'b1;
        rd_bank      <= rd_sel;
        read_ready_r <= 1'b0;
      end else if (rd_active) begin
        read_ready_r <= 1'b0;
        if (rd_release) begin
          rd_active <= 1'b0;
          rd_size   <= '0;
        end
      end else begin
        read_ready_r <= |full;
        rd_size      <= (|full) ? wcount[rd_sel] : '0;
      end

      if (i_write_stb && !wr_en) o_overflow  <= 1'b1;
      if (i_read_stb && !rd_ok)  o_underflow <= 1'b1;
    end
  end

  assign o_write_size = PPFIFO_SIZE_WIDTH'(DEPTH_C);
  assign o_read_ready = read_ready_r;
  assign o_read_size  = PPFIFO_SIZE_WIDTH'(rd_size);

  ppfifo_dpram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(CW)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_en),
    .waddr(waddr),
    .wdata(i_write_data),
    .raddr(raddr),
    .rdata(o_read_data)
  );

endmodule

// File: tb/tb_ppfifo_sync.sv
// Bench for ppfifo_sync: directed producer/consumer sequences, a queue-based
// ownership model compared every cycle, and literal expectations at key points.
module tb_ppfifo_sync;

  localparam int DEPTH = 512;

  logic        clk;
  logic        rst;
  logic [1:0]  o_write_ready;
  logic [1:0]  i_write_activate;
  logic [23:0] o_write_size;
  logic        i_write_stb;
  logic [31:0] i_write_data;
  logic        o_read_ready;
  logic        i_read_activate;
  logic [23:0] o_read_size;
  logic        i_read_stb;
  logic [31:0] o_read_data;
  logic        o_overflow;
  logic        o_underflow;

  ppfifo_sync #(.DATA_WIDTH(32), .ADDRESS_WIDTH(9)) dut (
    .clk             (clk),
    .rst             (rst),
    .o_write_ready   (o_write_ready),
    .i_write_activate(i_write_activate),
    .o_write_size    (o_write_size),
    .i_write_stb     (i_write_stb),
    .i_write_data    (i_write_data),
    .o_read_ready    (o_read_ready),
    .i_read_activate (i_read_activate),
    .o_read_size     (o_read_size),
    .i_read_stb      (i_read_stb),
    .o_read_data     (o_read_data),
    .o_overflow      (o_overflow),
    .o_underflow     (o_underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // model: which agent owns each bank, the completed-bank queue, stored words
  int          m_wr = -1;
  int          m_rd = -1;
  int          m_idx = 0;
  int          m_len [2] = '{0, 0};
  logic [31:0] m_words [2][DEPTH];
  int          done_q[$];
  bit          m_ready = 0;
  int          m_size = 0;
  bit          m_ovf = 0;
  bit          m_udf = 0;
  int          pre_wr, pre_rd, front;
  bit          acc, nr;
  bit [1:0]    free_pre;

  function automatic bit [1:0] free_now();
    bit [1:0] f;
    for (int n = 0; n < 2; n++) f[n] = !(m_wr == n || m_rd == n);
    foreach (done_q[i]) f[done_q[i]] = 1'b0;
    return f;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_wr = -1; m_rd = -1; m_idx = 0; m_len = '{0, 0};
      done_q.delete();
      m_ready = 0; m_size = 0; m_ovf = 0; m_udf = 0;
    end else begin
      pre_wr   = m_wr;
      pre_rd   = m_rd;
      free_pre = free_now();
      acc      = i_read_activate && m_ready;
      nr       = (pre_rd < 0) && !acc && (done_q.size() > 0);
      front    = (done_q.size() > 0) ? done_q[0] : 0;
      if (acc) begin
        m_rd  = done_q.pop_front();
        m_idx = 0;
      end else if (pre_rd >= 0) begin
        if (i_read_stb) begin
          if (m_idx < m_len[pre_rd]) m_idx++;
          else m_udf = 1;
        end
        if (!i_read_activate) begin
          m_rd   = -1;
          m_size = 0;
        end
      end
      if (i_read_stb && pre_rd < 0) m_udf = 1;
      if (pre_rd < 0 && !acc) m_size = nr ? m_len[front] : 0;
      m_ready = nr;
      if (i_write_activate != 2'b11) begin
        if (i_write_stb) begin
          if (pre_wr >= 0 && i_write_activate[pre_wr] && m_len[pre_wr] < DEPTH) begin
            m_words[pre_wr][m_len[pre_wr]] = i_write_data;
            m_len[pre_wr]++;
          end else m_ovf = 1;
        end
        if (pre_wr >= 0 && !i_write_activate[pre_wr]) begin
          if (m_len[pre_wr] > 0) done_q.push_back(pre_wr);
          m_wr = -1;
        end
        for (int n = 0; n < 2; n++)
          if (i_write_activate[n] && free_pre[n]) begin
            m_wr     = n;
            m_len[n] = 0;
          end
      end else if (i_write_stb) m_ovf = 1;
    end
  end

  // per-cycle compare, after the edge has settled
  always @(posedge clk) begin
    #2;
    if (rst) begin
      check("cyc_write_ready", o_write_ready, free_now());
      check("cyc_read_ready", o_read_ready, m_ready);
      check("cyc_read_size", o_read_size, m_size);
      check("cyc_write_size", o_write_size, DEPTH);
      check("cyc_overflow", o_overflow, m_ovf);
      check("cyc_underflow", o_underflow, m_udf);
      if (m_rd >= 0 && m_idx < m_len[m_rd])
        check("cyc_read_data", o_read_data, m_words[m_rd][m_idx]);
    end
  end

  // driver tasks
  task automatic write_burst(input int bank, input int n, input logic [31:0] base);
    i_write_activate = 2'b01 << bank;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      i_write_stb  = 1'b1;
      i_write_data = base + 32'(i);
      @(negedge clk);
    end
    i_write_stb      = 1'b0;
    i_write_activate = 2'b00;
    @(negedge clk);
  endtask

  task automatic wait_read_ready();
    int n = 0;
    while (!o_read_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("read_ready_wait", o_read_ready, 1'b1);
  endtask

  task automatic read_burst(input int k, input bit gaps);
    i_read_activate = 1'b1;
    @(negedge clk);
    for (int i = 0; i < k; i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        for (int j = 0; j < g; j++) begin
          i_read_stb = 1'b0;
          @(negedge clk);
        end
      end
      check("read_data", o_read_data, exp_q.pop_front());
      i_read_stb = 1'b1;
      @(negedge clk);
    end
    i_read_stb = 1'b0;
  endtask

  task automatic read_release();
    i_read_activate = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    i_write_activate = 2'b00;
    i_write_stb = 1'b0;
    i_write_data = '0;
    i_read_activate = 1'b0;
    i_read_stb = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_write_ready", o_write_ready, 2'b11);
    check("rst_read_ready", o_read_ready, 1'b0);
    check("rst_read_size", o_read_size, 0);
    check("rst_write_size", o_write_size, 512);
    check("rst_read_data", o_read_data, 0);
    rst = 1'b1;
    @(negedge clk);

    // basic transfer
    write_burst(0, 4, 32'hA0);
    check("basic_offer_pipelined", o_read_ready, 1'b0);
    @(negedge clk);
    check("basic_offer_ready", o_read_ready, 1'b1);
    check("basic_offer_size", o_read_size, 4);
    check("basic_bank0_busy", o_write_ready, 2'b10);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + 32'(i));
    read_burst(4, 1'b0);
    read_release();
    check("basic_release_ready", o_write_ready, 2'b11);
    check("basic_release_size", o_read_size, 0);

    // fill order
    write_burst(1, 3, 32'hB0);
    write_burst(0, 2, 32'hC0);
    wait_read_ready();
    check("order_first_size", o_read_size, 3);
    for (int i = 0; i < 3; i++) exp_q.push_back(32'hB0 + 32'(i));
    read_burst(3, 1'b0);
    read_release();
    wait_read_ready();
    check("order_second_size", o_read_size, 2);
    exp_q.push_back(32'hC0);
    exp_q.push_back(32'hC1);
    read_burst(2, 1'b0);
    read_release();

    // zero-strobe activate/release
    i_write_activate = 2'b10;
    @(negedge clk);
    i_write_activate = 2'b00;
    @(negedge clk);
    check("empty_release_wready", o_write_ready, 2'b11);
    check("empty_release_rready", o_read_ready, 1'b0);
    @(negedge clk);
    check("empty_release_rready2", o_read_ready, 1'b0);

    // underflow
    check("pre_underflow", o_underflow, 1'b0);
    write_burst(0, 4, 32'hD0);
    wait_read_ready();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hD0 + 32'(i));
    read_burst(4, 1'b0);
    i_read_stb = 1'b1;
    @(negedge clk);
    i_read_stb = 1'b0;
    check("underflow_flag", o_underflow, 1'b1);
    read_release();

    // overflow
    check("pre_overflow", o_overflow, 1'b0);
    write_burst(0, 514, 32'h1000);
    wait_read_ready();
    check("overflow_size", o_read_size, 512);
    check("overflow_flag", o_overflow, 1'b1);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(32'h1000 + 32'(i));
    read_burst(DEPTH, 1'b0);
    read_release();

    // concurrent write on bank1 while partially reading bank0
    write_burst(0, 4, 32'hE0);
    wait_read_ready();
    exp_q.push_back(32'hE0);
    exp_q.push_back(32'hE1);
    fork
      read_burst(2, 1'b1);
      begin
        @(negedge clk);
        write_burst(1, 4, 32'hF0);
      end
    join
    read_release();
    check("partial_bank0_empty", o_write_ready, 2'b01);
    check("partial_read_ready", o_read_ready, 1'b0);
    check("partial_read_size", o_read_size, 0);
    @(negedge clk);
    check("partial_offer_ready", o_read_ready, 1'b1);
    check("partial_offer_size", o_read_size, 4);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hF0 + 32'(i));
    read_burst(4, 1'b1);
    read_release();

    // asynchronous reset mid-operation
    write_burst(1, 2, 32'h77);
    i_write_activate = 2'b01;
    @(negedge clk);
    i_write_stb  = 1'b1;
    i_write_data = 32'h55;
    @(negedge clk);
    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_write_ready", o_write_ready, 2'b11);
    check("async_rst_read_ready", o_read_ready, 1'b0);
    check("async_rst_read_size", o_read_size, 0);
    check("async_rst_overflow", o_overflow, 1'b0);
    check("async_rst_underflow", o_underflow, 1'b0);
    check("async_rst_read_data", o_read_data, 0);
    check("async_rst_write_size", o_write_size, 512);
    @(negedge clk);
    i_write_activate = 2'b00;
    i_write_stb = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // recovery transfer after reset
    write_burst(0, 2, 32'h300);
    wait_read_ready();
    check("recover_size", o_read_size, 2);
    exp_q.push_back(32'h300);
    exp_q.push_back(32'h301);
    read_burst(2, 1'b0);
    read_release();
    check("recover_flags", {o_overflow, o_underflow}, 2'b00);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
